// File: rtl/dispatch_queue_if.sv
// Dual-issue decode -> dispatch queue interface, plus the shared decoded-entry type.
// slave = queue side, master = decoder/dispatch side.
package dispatch_queue_pkg;
   typedef struct packed {
      logic        inst_valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } id_dispatch_t;
endpackage

interface dispatch_queue_if
   import dispatch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [1:0]            push_en;
   id_dispatch_t [1:0]    push_data;
   logic                  push_ready;
   logic [1:0]            pop_en;
   id_dispatch_t [1:0]    dispatch_o;
   logic [1:0]            ages;
   logic                  empty;
   logic                  full;
   logic [CntW-1:0]       occupancy;

   modport slave (
      input  push_en, push_data, pop_en,
      output push_ready, dispatch_o, ages, empty, full, occupancy
   );

   modport master (
      output push_en, push_data, pop_en,
      input  push_ready, dispatch_o, ages, empty, full, occupancy
   );
endinterface

// File: rtl/dispatch_queue.sv
// Dual-issue in-order instruction queue feeding dispatch; two-bank (even/odd) storage.
// Optional full-cycle perf counter enabled by defining DQUEUE_PERF_EN.
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   dispatch_queue_if.slave  dq
`ifdef DQUEUE_PERF_EN
   ,
   output logic [31:0]      full_cycles
`endif
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned RowW = PtrW - 1;
   localparam int unsigned Half = DEPTH / 2;
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;

   id_dispatch_t    mem_q [2][Half];

   logic [RowW-1:0] rd_row [2];
   logic [1:0]      slot_valid;
   logic [1:0]      oldest_mask;

   logic            push_ready;
   logic            push_fire;
   logic [1:0]      n_push;
   logic [1:0]      n_pop;
   id_dispatch_t    push_first;

   logic [1:0]      wr_en;
   logic [RowW-1:0] wr_row [2];
   id_dispatch_t    wr_data [2];
   logic [PtrW-1:0] wr_idx1;

   // Outputs depend only on registered state, keeping the dispatch -> pop_en loop acyclic.
   always_comb begin
      oldest_mask   = head_q[0] ? 2'b10 : 2'b01;
      push_ready    = (count_q <= CntW'(DEPTH - 2));
      rd_row[0]     = head_q[PtrW-1:1] + RowW'(head_q[0]);
      rd_row[1]     = head_q[PtrW-1:1];
      slot_valid[0] = head_q[0] ? (count_q >= CntW'(2)) : (count_q != '0);
      slot_valid[1] = head_q[0] ? (count_q != '0) : (count_q >= CntW'(2));
      for (int b = 0; b < 2; b++) begin
         dq.dispatch_o[b] = slot_valid[b] ? mem_q[b][rd_row[b]] : '0;
      end
      dq.ages       = oldest_mask;
      dq.push_ready = push_ready;
      dq.empty      = (count_q == '0);
      dq.full       = (count_q == CntW'(DEPTH));
      dq.occupancy  = count_q;
   end

   // Only 00, oldest-only and both (with enough valid entries) retire anything.
   always_comb begin
      n_pop = 2'd0;
      if (dq.pop_en == 2'b11) begin
         if (count_q >= CntW'(2)) n_pop = 2'd2;
      end else if (dq.pop_en == oldest_mask && count_q != '0) begin
         n_pop = 2'd1;
      end
   end

   always_comb begin
      push_fire  = push_ready && !flush;
      n_push     = push_fire ? ({1'b0, dq.push_en[0]} + {1'b0, dq.push_en[1]}) : 2'd0;
      push_first = dq.push_en[0] ? dq.push_data[0] : dq.push_data[1];
      wr_idx1    = tail_q + PtrW'(1);
      wr_en      = '0;
      wr_row[0]  = '0;
      wr_row[1]  = '0;
      wr_data[0] = '0;
      wr_data[1] = '0;
      // Consecutive indices always land in different banks, so each bank sees at most one write.
      if (n_push != 2'd0) begin
         wr_en[tail_q[0]]   = 1'b1;
         wr_row[tail_q[0]]  = tail_q[PtrW-1:1];
         wr_data[tail_q[0]] = push_first;
      end
      if (n_push == 2'd2) begin
         wr_en[wr_idx1[0]]   = 1'b1;
         wr_row[wr_idx1[0]]  = wr_idx1[PtrW-1:1];
         wr_data[wr_idx1[0]] = dq.push_data[1];
      end
   end

   always_comb begin
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PtrW'(n_pop);
         tail_d  = tail_q + PtrW'(n_push);
         count_d = count_q + CntW'(n_push) - CntW'(n_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately unreset; reads are masked by count.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (wr_en[b]) mem_q[b][wr_row[b]] <= wr_data[b];
      end
   end

`ifdef DQUEUE_PERF_EN
   logic [31:0] full_cycles_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_cycles_q <= '0;
      end else if (count_q == CntW'(DEPTH) && full_cycles_q != 32'hFFFF_FFFF) begin
         full_cycles_q <= full_cycles_q + 32'd1;
      end
   end

   assign full_cycles = full_cycles_q;
`endif

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Dual-issue instruction queue between the two decoders and `dispatch`. It accepts up to two decoded `id_dispatch_t` entries per cycle in program order and presents the two oldest entries to `dispatch` as `dispatch_i[1:0]`, together with `ages`. It retires entries according to `dispatch`'s per-slot issue mask (`invalid_en`). It is the producer end of the dispatch handshake: it owns ordering, occupancy and back-pressure to the decoders.

## Interface

Parameters:
- `DEPTH`, default 8: total entries. Must be a power of 2 and ≥ 4. Storage is split into two banks (even/odd index) of `DEPTH/2` entries each.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous clear from ctrl.
- `push_en` in 2: per-decoder valid. Bit 0 is older in program order.
- `push_data` in `id_dispatch_t[2]`: decoded entries.
- `push_ready` out 1: the queue can take two entries this cycle.
- `pop_en` in 2: per-output-slot issue mask from `dispatch.invalid_en`.
- `dispatch_o` out `id_dispatch_t[2]`: head entries, wired to `dispatch.dispatch_i`.
- `ages` out 2: one-hot; the set bit marks the output slot that holds the oldest entry.
- `empty` out 1: count == 0.
- `full` out 1: count == `DEPTH`.
- `occupancy` out `$clog2(DEPTH)+1`: current count.
- `full_cycles` out 32: present only with `DQUEUE_PERF_EN`.

## Operation

**State**
- `head`, `tail`: `$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`.
- `count`: `$clog2(DEPTH)+1` bits.
- Entry at index `i` lives in bank `i[0]`, row `i>>1`.

**Push**
- Accepted only when `push_ready` = (`DEPTH - count` ≥ 2) and `flush` = 0.
- Active `push_en` bits are compacted: 2'b11 writes slot0 to `tail` and slot1 to `tail+1`. 2'b01 or 2'b10 writes the single entry to `tail`.
- `tail += popcount(push_en)`.
- A push while `push_ready` = 0 is dropped. The decoder must hold its entries.

**Output**
- Slot `b` shows bank `b` at row `(head>>1) + (b < head[0] ? 1 : 0)`, modulo `DEPTH/2`.
- The oldest entry is in slot `head[0]`, so `ages = 1 << head[0]`.
- The older slot is valid when `count` ≥ 1; the younger slot is valid when `count` ≥ 2.
- An invalid slot drives the whole struct as zero, including `inst_valid`.

**Pop**
- Legal masks are: 00; the oldest slot only (if valid); both slots (if both valid).
- Any other mask is ignored: no pointer change, equivalent to 00.
- `head += popcount(pop_en)`.

**Update**
- `count <= count + pushed - popped`.
- Push and pop in the same cycle are allowed, including at `full` and `empty`.
- `push_ready` comes from the pre-pop `count`, so a full queue does not accept a push even in a cycle where it pops.

**Flush**
- Highest priority. `head`, `tail` and `count` go to 0.
- Pushes and pops in the flush cycle are discarded.

**Reset**
- `head`, `tail` and `count` go to 0.
- Entry storage is not reset; outputs are masked by `count`.

## Timing

- Reset values: `dispatch_o` = all zero, `ages` = 2'b01, `empty` = 1, `full` = 0, `push_ready` = 1, `occupancy` = 0, `full_cycles` = 0.
- Push latency is 1 cycle. An entry written at edge N is visible on `dispatch_o` after edge N. There is no combinational push-to-output bypass.
- A pop takes effect at the edge. The next entries appear in the following cycle.
- No combinational path runs from `pop_en` or `push_en` to any output. All outputs are functions of registered state only. This keeps the `dispatch` → `invalid_en` loop acyclic.
- Wrap-around: the pointers wrap modulo `DEPTH`. The bank row for the younger slot wraps modulo `DEPTH/2`.

## Configuration

- `DQUEUE_PERF_EN` defined:
  - `full_cycles` counts clock cycles with `full` = 1.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by `rst`, not by `flush`.
- `DQUEUE_PERF_EN` undefined: the `full_cycles` port and its counter are absent. All other behaviour is identical.

## Test plan

- **Reset then push.** Push A,B (`push_en` = 11) at cycle 1 → cycle 2: slot0 = A, slot1 = B, `ages` = 01, `occupancy` = 2.
- **Odd head.** Push A,B,C and pop 01 → slot1 = B (oldest), `ages` = 10, slot0 = C. Then pop 11 → `empty` = 1 and `dispatch_o` = 0.
- **Full boundary with `DEPTH` = 8.**
  - Fill 8 entries → `full` = 1, `push_ready` = 0.
  - Push 11 together with pop 11 → the push is dropped and `occupancy` = 6.
  - Next cycle `push_ready` = 1.
- **Illegal pop masks.** With 1 entry, pop 11 → ignored, `occupancy` stays 1. With 2 entries, pop only the younger slot → ignored.
- **Flush priority.** Flush with simultaneous push 11 and pop 01 on 5 entries → `occupancy` = 0, `ages` = 01. A mid-stream `rst` gives the same result asynchronously.
- **Perf counter (`DQUEUE_PERF_EN`).** Hold `full` for 10 cycles → `full_cycles` = 10. A flush leaves it at 10.
